// File: rtl/mw_mem_ctrl_if.sv
// Data-memory handshake between the MW-stage controller and the memory port.
interface mw_mem_ctrl_if;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;
    logic dmem_err;

    modport master (output dmem_req, output dmem_we, input dmem_ack, input dmem_err);
    modport slave  (input dmem_req, input dmem_we, output dmem_ack, output dmem_err);
endinterface

// File: rtl/mw_mem_ctrl.sv
// MW-stage data-memory controller: issues loads/stores, stalls the pipe while an
// access is outstanding, and turns bus errors/timeouts into a pipeline flush.
module mw_mem_ctrl #(
    parameter int unsigned TO_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_rd_mw,
    input  logic            mem_wr_mw,
    input  logic            trap_mw,
    input  logic            br_taken_de,
    input  logic [TO_W-1:0] to_limit,
    input  logic            cnt_clr,
    mw_mem_ctrl_if.master   mem_if,
    output logic            stall_fd,
    output logic            stall_de,
    output logic            flush_fd,
    output logic            flush_de,
    output logic            bus_err,
    output logic [1:0]      err_cause,
    output logic [31:0]     stall_cnt
);

    localparam int unsigned CNT_W = 32;
    localparam logic [1:0]  CAUSE_BUS = 2'b01;
    localparam logic [1:0]  CAUSE_TO  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             we_q, we_d;
    logic [1:0]       err_cause_q, err_cause_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic access;
    logic req_c, we_c, stall_c, flush_fd_c, flush_de_c, bus_err_c, timeout_hit_c;
    logic ack, err;

    assign access = mem_rd_mw | mem_wr_mw;
    assign ack    = mem_if.dmem_ack;
    assign err    = mem_if.dmem_err;

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            to_cnt_q    <= '0;
            we_q        <= 1'b0;
            err_cause_q <= 2'b00;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            we_q        <= we_d;
            err_cause_q <= err_cause_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state and combinational handshake/pipeline-control outputs.
    always_comb begin
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        we_d          = we_q;
        err_cause_d   = err_cause_q;
        stall_cnt_d   = stall_cnt_q;
        req_c         = 1'b0;
        we_c          = 1'b0;
        timeout_hit_c = 1'b0;
        stall_c       = 1'b0;
        bus_err_c     = 1'b0;
        flush_fd_c    = 1'b0;
        flush_de_c    = 1'b0;

        // state_q is forced to IDLE while rst is low, so gating IDLE with rst
        // keeps every combinational output quiet during reset.
        unique case (state_q)
            ST_IDLE: begin
                req_c = rst & access & ~trap_mw;
                we_c  = req_c & mem_wr_mw;
            end
            ST_WAIT: begin
                req_c         = 1'b1;
                we_c          = we_q;
                timeout_hit_c = (to_limit != '0) && (to_cnt_q == to_limit - TO_W'(1))
                                && !ack && !err;
            end
        endcase

        stall_c   = req_c & ~ack & ~err & ~timeout_hit_c;
        bus_err_c = req_c & ~ack & (err | timeout_hit_c);

        if (bus_err_c || (rst && state_q == ST_IDLE && trap_mw)) begin
            flush_fd_c = 1'b1;
            flush_de_c = 1'b1;
            stall_c    = 1'b0;
        end else begin
            flush_fd_c = rst & br_taken_de & ~stall_c;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (req_c && !ack && !err) begin
                    state_d  = ST_WAIT;
                    to_cnt_d = '0;
                    we_d     = mem_wr_mw;
                end
            end
            ST_WAIT: begin
                if (ack || err || timeout_hit_c) state_d = ST_IDLE;
                else                              to_cnt_d = to_cnt_q + TO_W'(1);
            end
        endcase

        // ack has already masked bus_err, so err here outranks the timeout.
        if (bus_err_c) err_cause_d = err ? CAUSE_BUS : CAUSE_TO;

        if (cnt_clr)                       stall_cnt_d = '0;
        else if (stall_c && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    assign mem_if.dmem_req = req_c;
    assign mem_if.dmem_we  = we_c;
    assign stall_fd        = stall_c;
    assign stall_de        = stall_c;
    assign flush_fd        = flush_fd_c;
    assign flush_de        = flush_de_c;
    assign bus_err         = bus_err_c;
    assign err_cause       = err_cause_q;
    assign stall_cnt       = stall_cnt_q;

endmodule
